// File: rtl/bubble_timing_sequencer_if.sv
// bubble_timing_sequencer_if: host control inputs and timing outputs of the bubble timing sequencer
// Signals:
//   bubble_module_enable  active-low module enable (high forces shift/rep inactive, boot 0)
//   bubble_shift_enable   active-low shift request, asynchronous
//   replicator_enable     active-low replicate request, asynchronous
//   bootloop_enable       active-high page select request, asynchronous
//   clock_out             free-running divided clock
//   tick                  one-master-cycle sequencer tick strobe
//   coil_en               {+Y,-Y,-X,+X} coil drives, active-high
//   coil_run              high in START, RUN and STOP
//   position_change       high while +Y is driven alone
//   data_out_notice       detector clamp window
//   data_out_strobe       detector strobe window
//   position_latch        replicator window
//   page_select           synchronized bootloop
//   rotation_count        completed rotations since reset, wrapping
// Modports: master drives the requests and observes timing; slave is the sequencer.
interface bubble_timing_sequencer_if #(
    parameter int ROT_W = 16
);
    logic             bubble_module_enable;
    logic             bubble_shift_enable;
    logic             replicator_enable;
    logic             bootloop_enable;
    logic             clock_out;
    logic             tick;
    logic [3:0]       coil_en;
    logic             coil_run;
    logic             position_change;
    logic             data_out_notice;
    logic             data_out_strobe;
    logic             position_latch;
    logic             page_select;
    logic [ROT_W-1:0] rotation_count;

    modport master (
        output bubble_module_enable, bubble_shift_enable, replicator_enable, bootloop_enable,
        input  clock_out, tick, coil_en, coil_run, position_change, data_out_notice,
               data_out_strobe, position_latch, page_select, rotation_count
    );

    modport slave (
        input  bubble_module_enable, bubble_shift_enable, replicator_enable, bootloop_enable,
        output clock_out, tick, coil_en, coil_run, position_change, data_out_notice,
               data_out_strobe, position_latch, page_select, rotation_count
    );
endinterface

// File: rtl/bubble_timing_sequencer.sv
// bubble_timing_sequencer: coil-drive and sense timing generator for the bubble memory emulator
// Ports:
//   master_clock  48 MHz system clock
//   reset_n       asynchronous active-low reset
//   bus           bubble_timing_sequencer_if.slave: host requests in, coil/window/page/rotation outputs
// Divides master_clock into a sequencer tick and clock_out, synchronizes the host requests on tick,
// runs the IDLE/START/RUN/STOP coil state machine and derives the sense windows from the phase.
module bubble_timing_sequencer #(
    parameter int TICK_DIV     = 4,
    parameter int CLKOUT_DIV   = 12,
    parameter int SYNC_STAGES  = 3,
    parameter int PERIOD       = 120,
    parameter int OVERLAP      = 3,
    parameter int START_LEN    = 2,
    parameter int STOP_LEN     = 29,
    parameter int CLAMP_START  = 36,
    parameter int STROBE_START = 58,
    parameter int STROBE_LEN   = 16,
    parameter int REP_START    = 1,
    parameter int REP_LEN      = 3,
    parameter int ROT_W        = 16
) (
    input logic                      master_clock,
    input logic                      reset_n,
    bubble_timing_sequencer_if.slave bus
);
    localparam int Q       = PERIOD / 4;
    localparam int PH_W    = $clog2(PERIOD);
    localparam int CNT_MAX = (START_LEN > STOP_LEN) ? START_LEN : STOP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TD_W    = $clog2(TICK_DIV);
    localparam int CK_W    = $clog2(CLKOUT_DIV);
    localparam logic [TD_W-1:0]  TD_LAST    = TD_W'(TICK_DIV - 1);
    localparam logic [CK_W-1:0]  CK_LAST    = CK_W'(CLKOUT_DIV / 2 - 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_LEN - 1);
    // Coil of each quadrant in rotation order -X, -Y, +X, +Y ({+Y,-Y,-X,+X}).
    localparam logic [3:0] SEQ [4] = '{4'b0010, 4'b0100, 4'b0001, 4'b1000};

    if (CLAMP_START > STROBE_START || STROBE_START + STROBE_LEN > PERIOD ||
        REP_START + REP_LEN > PERIOD || PERIOD % 4 != 0) begin : g_bad_params
        $error("bubble_timing_sequencer: inconsistent timing parameters");
    end

    typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;

    state_t           state, state_nx;
    logic [PH_W-1:0]  ph, ph_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             rep_hold, rep_nx;
    logic [ROT_W-1:0] rot_nx;
    logic [TD_W-1:0]  div_cnt;
    logic [CK_W-1:0]  ck_cnt;
    logic [3:0]       sync [SYNC_STAGES-1];
    logic [3:0]       req;
    logic             shift_a, rep_a, boot_a;
    int               p;
    logic [1:0]       k;
    logic             ov, run;
    logic [3:0]       coil_nx;
    logic             notice_nx, strobe_nx, latch_nx;

    // Free-running dividers, independent of the sequencer state.
    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt       <= '0;
            ck_cnt        <= '0;
            bus.tick      <= 1'b0;
            bus.clock_out <= 1'b1;
        end else begin
            div_cnt       <= (div_cnt == TD_LAST) ? '0 : div_cnt + 1'b1;
            ck_cnt        <= (ck_cnt == CK_LAST) ? '0 : ck_cnt + 1'b1;
            bus.tick      <= div_cnt == TD_LAST;
            bus.clock_out <= (ck_cnt == CK_LAST) ? ~bus.clock_out : bus.clock_out;
        end
    end

    // The tick-enabled state/output registers act as the last synchronizer stage,
    // so SYNC_STAGES-1 explicit stages precede them. Packing: {module_n, shift_n, rep_n, boot}.
    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES - 1; i++) sync[i] <= 4'b1110;
        end else if (bus.tick) begin
            sync[0] <= {bus.bubble_module_enable, bus.bubble_shift_enable,
                        bus.replicator_enable, bus.bootloop_enable};
            for (int i = 1; i < SYNC_STAGES - 1; i++) sync[i] <= sync[i-1];
        end
    end

    assign req     = sync[SYNC_STAGES-2];
    assign shift_a = ~req[3] & ~req[2];
    assign rep_a   = ~req[3] & ~req[1];
    assign boot_a  = ~req[3] & req[0];

    always_comb begin
        state_nx = state;
        ph_nx    = ph;
        cnt_nx   = cnt;
        rot_nx   = bus.rotation_count;
        case (state)
            IDLE: begin
                ph_nx = '0;
                if (shift_a) begin
                    state_nx = START;
                    cnt_nx   = '0;
                end
            end
            START: begin
                if (cnt == START_LAST) begin
                    state_nx = RUN;
                    ph_nx    = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN: begin
                if (ph == PH_LAST) begin
                    // A started rotation always completes before a stop is honoured.
                    rot_nx = bus.rotation_count + 1'b1;
                    ph_nx  = '0;
                    if (!shift_a) begin
                        state_nx = STOP;
                        cnt_nx   = '0;
                    end
                end else begin
                    ph_nx = ph + 1'b1;
                end
            end
            STOP: begin
                if (shift_a) begin
                    state_nx = RUN;
                    ph_nx    = '0;
                end else if (cnt == STOP_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Replicate request is captured as each rotation begins and held for it.
        rep_nx = (state_nx == RUN && ph_nx == '0) ? rep_a : rep_hold;
    end

    // Outputs are decoded from the next state/phase so the registered outputs line up with them.
    always_comb begin
        p         = int'(ph_nx);
        run       = state_nx == RUN;
        k         = (p >= 3 * Q) ? 2'd3 : (p >= 2 * Q) ? 2'd2 : (p >= Q) ? 2'd1 : 2'd0;
        ov        = (p - int'(k) * Q) >= Q - OVERLAP;
        coil_nx   = run ? (SEQ[k] | (ov ? SEQ[k + 2'd1] : 4'b0000))
                        : (state_nx == IDLE ? 4'b0000 : 4'b0010);
        notice_nx = run && p >= CLAMP_START && p <= STROBE_START + STROBE_LEN - 1;
        strobe_nx = run && p >= STROBE_START && p <= STROBE_START + STROBE_LEN - 1;
        latch_nx  = run && rep_nx && p >= REP_START && p <= REP_START + REP_LEN - 1;
    end

    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            ph                  <= '0;
            cnt                 <= '0;
            rep_hold            <= 1'b0;
            bus.coil_en         <= '0;
            bus.coil_run        <= 1'b0;
            bus.position_change <= 1'b0;
            bus.data_out_notice <= 1'b0;
            bus.data_out_strobe <= 1'b0;
            bus.position_latch  <= 1'b0;
            bus.page_select     <= 1'b0;
            bus.rotation_count  <= '0;
        end else if (bus.tick) begin
            state               <= state_nx;
            ph                  <= ph_nx;
            cnt                 <= cnt_nx;
            rep_hold            <= rep_nx;
            bus.coil_en         <= coil_nx;
            bus.coil_run        <= state_nx != IDLE;
            bus.position_change <= coil_nx == 4'b1000;
            bus.data_out_notice <= notice_nx;
            bus.data_out_strobe <= strobe_nx;
            bus.position_latch  <= latch_nx;
            bus.page_select     <= boot_a;
            bus.rotation_count  <= rot_nx;
        end
    end
endmodule

// File: doc/bubble_timing_sequencer.md
Name: bubble_timing_sequencer

Overview:
Parametrised coil-drive and sense timing generator for the bubble memory emulator. It divides master_clock into a sequencer tick and runs a start/run/stop state machine for the rotating-field coils. It derives detector clamp/strobe, replicator latch and page-select windows from a programmable rotation phase counter, and counts completed rotations. It sits between the host bus control inputs and the bubble data path / position tracker.

Parameters:
TICK_DIV, 4, master_clock cycles per sequencer tick (48 MHz -> 12 MHz); >=2
CLKOUT_DIV, 12, master_clock cycles per clock_out period; even, >=2
SYNC_STAGES, 3, input synchronizer depth in ticks; >=2
PERIOD, 120, ticks per field rotation; multiple of 4; Q = PERIOD/4
OVERLAP, 3, ticks at the end of each quadrant where the next coil is also driven; < Q
START_LEN, 2, ticks -X is held alone before the first rotation
STOP_LEN, 29, ticks -X is held after the last rotation
CLAMP_START, 36, phase where data_out_notice rises
STROBE_START, 58, phase where data_out_strobe rises
STROBE_LEN, 16, strobe width in ticks; notice and strobe both fall after STROBE_START+STROBE_LEN-1
REP_START, 1, phase where position_latch rises
REP_LEN, 3, position_latch width in ticks
ROT_W, 16, rotation counter width
Elaboration must fail if any of these hold: CLAMP_START>STROBE_START; STROBE_START+STROBE_LEN>PERIOD; REP_START+REP_LEN>PERIOD; PERIOD%4!=0.

Ports:
master_clock  in  1  48 MHz system clock
reset_n  in  1  asynchronous active-low reset
bubble_module_enable  in  1  active-low; when high, shift/rep are forced inactive and bootloop is forced to 0
bubble_shift_enable  in  1  active-low shift request, asynchronous
replicator_enable  in  1  active-low replicate request, asynchronous
bootloop_enable  in  1  active-high page select request, asynchronous
clock_out  out  1  free-running divided clock, reset value 1
tick  out  1  one-master-cycle sequencer tick strobe
coil_en  out  4  {+Y,-Y,-X,+X}, active-high
coil_run  out  1  high in START, RUN and STOP
position_change  out  1  high while +Y is driven alone
data_out_notice  out  1  clamp window
data_out_strobe  out  1  strobe window; data is valid at its falling edge
position_latch  out  1  replicator window
page_select  out  1  synchronized bootloop
rotation_count  out  ROT_W  completed rotations since reset; wraps

Behaviour:
- Reset (asynchronous assert, synchronous deassert is not required): all outputs 0 except clock_out=1; dividers=0; synchronizer stages hold the inactive value (shift/rep inactive, boot 0); state=IDLE; ph=0.
- Dividers: tick pulses one master cycle every TICK_DIV cycles. clock_out toggles every CLKOUT_DIV/2 cycles. Neither divider depends on state.
- Synchronizer: advances on tick only. An input change is visible to the FSM exactly SYNC_STAGES ticks later. page_select equals the synchronized boot value.
- All state, ph and outputs are registered and update only on tick. Outputs depend on the registered state and ph with no combinational path from inputs.
- FSM states and transitions:
  IDLE: coil_en=0000; ph=0. When shift is active, go to START with cnt=0.
  START: coil_en=0010 (-X). After START_LEN ticks, go to RUN with ph=0.
  RUN: ph counts 0..PERIOD-1 and wraps. rotation_count increments at each wrap and at exit. Quadrant k=ph/Q drives the coil sequence -X, -Y, +X, +Y. In the last OVERLAP ticks of quadrant k, the coil of quadrant k+1 is also driven; at k=3 the next coil is -X. If shift is inactive when ph=PERIOD-1, go to STOP with cnt=0; otherwise wrap. A deassert mid-rotation always completes the rotation.
  STOP: coil_en=0010. If shift becomes active, go to RUN with ph=0 on the next tick. Otherwise, after STOP_LEN ticks, go to IDLE.
- Windows apply in RUN only; they are 0 in IDLE, START and STOP:
  - data_out_notice: ph in [CLAMP_START, STROBE_START+STROBE_LEN-1].
  - data_out_strobe: ph in [STROBE_START, STROBE_START+STROBE_LEN-1].
  - position_latch: ph in [REP_START, REP_START+REP_LEN-1] and rep active, where rep is sampled at ph=0 and held for the rotation.
  - position_change: +Y driven and no other coil driven.
- bubble_module_enable going high in RUN acts as a shift deassert, so the rotation completes and the FSM then runs STOP.
- Reset mid-rotation clears everything immediately. Coils go to 0 without a STOP hold.

Test Plan:
- Reset with defaults: all outputs 0, clock_out=1. Release reset, hold shift inactive for 1000 ticks -> IDLE throughout; clock_out period is 12 master cycles; tick pulses every 4 master cycles.
- Shift asserted at tick T -> START at T+3 with coil_en=0010 for 2 ticks. RUN ph=0 at T+5. Coil sequence: 0010x27, 0110x3, 0100x27, 0101x3, 0001x27, 1001x3, 1000x27, 1010x3. position_change high for 27 ticks per rotation.
- Continuous RUN with rep active: per rotation, position_latch high at ph 1..3, data_out_notice at ph 36..73, data_out_strobe at ph 58..73. rotation_count increments by 1 every 120 ticks.
- Deassert shift at ph=50 -> rotation completes to ph=119, then STOP with coil_en=0010 for 29 ticks, then IDLE. Reassert shift at STOP tick 10 -> RUN ph=0 on the next tick with no START phase.
- bubble_module_enable=1 with shift active and boot=1 -> FSM stays IDLE and page_select=0. Set it to 0 -> page_select=1 three ticks later.
- Assert reset_n low at ph=70 -> outputs clear in the same master cycle; the counter resumes from IDLE after release.
